// File: rtl/note_sequencer.sv
// Step-table driven note sequencer: plays a list of per-channel pitch,
// enable and waveform updates, holding each step for a whole number of ticks.
//
// Handshake/control semantics: start and stop are level-sampled on every
// rising edge (no valid/ready pairing). stop has priority over everything
// else. wr_en commits one table entry per cycle, in any state. The read
// done by APPLY returns the contents from before a same-cycle write.
module note_sequencer #(
    parameter int NUM         = 4,
    parameter int C           = 14,
    parameter int DEPTH       = 16,
    parameter int DW          = 8,
    parameter int TICK_CYCLES = 120_000,
    localparam int AW         = $clog2(DEPTH),
    localparam int CHW        = (NUM > 1) ? $clog2(NUM) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [AW-1:0]     wr_addr,
    input  logic [CHW-1:0]    wr_chan,
    input  logic              wr_ena,
    input  logic [1:0]        wr_wave,
    input  logic [C-1:0]      wr_pitch,
    input  logic [DW-1:0]     wr_dur,
    input  logic              wr_last,
    input  logic              start,
    input  logic              stop,
    input  logic              loop,
    output logic [NUM*C-1:0]  pitches,
    output logic [NUM-1:0]    channel_ena,
    output logic [NUM*2-1:0]  waveforms,
    output logic              busy,
    output logic [AW-1:0]     step_idx,
    output logic              done,
    output logic [1:0]        dbg_state
);

    localparam int PW = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        APPLY = 2'd1,
        HOLD  = 2'd2
    } state_t;

    typedef struct packed {
        logic [CHW-1:0] chan;
        logic           ena;
        logic [1:0]     wave;
        logic [C-1:0]   pitch;
        logic [DW-1:0]  dur;
        logic           last;
    } step_t;

    step_t          step_mem [DEPTH];
    step_t          cur;
    state_t         state;
    state_t         state_n;
    logic [PW-1:0]  presc;
    logic [DW-1:0]  dur_cnt;
    logic           hold_last;
    logic           tick_wrap;
    logic           apply_last;
    logic           step_last;
    logic           expire;
    logic           finish;
    logic [AW-1:0]  idx_n;

    assign cur       = step_mem[step_idx];
    assign tick_wrap = (presc == PW'(TICK_CYCLES - 1));
    assign busy      = (state != IDLE);
    assign dbg_state = state;

    // Step table: write port only, never reset; read is combinational.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            step_mem[wr_addr] <= {wr_chan, wr_ena, wr_wave, wr_pitch, wr_dur, wr_last};
        end
    end

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Next state, next step index and step expiry; the last table entry
    // always ends the sequence so the index never wraps silently.
    always_comb begin
        state_n    = state;
        expire     = 1'b0;
        finish     = 1'b0;
        idx_n      = step_idx;
        apply_last = cur.last || (step_idx == AW'(DEPTH - 1));
        step_last  = (state == APPLY) ? apply_last : hold_last;
        case (state)
            IDLE: begin
                if (start) begin
                    state_n = APPLY;
                    idx_n   = '0;
                end
            end
            APPLY: begin
                if (cur.dur == '0) begin
                    expire = 1'b1;
                end else begin
                    state_n = HOLD;
                end
            end
            HOLD: begin
                if (tick_wrap && (dur_cnt == DW'(1))) begin
                    expire = 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase
        if (expire) begin
            if (!step_last) begin
                state_n = APPLY;
                idx_n   = step_idx + 1'b1;
            end else if (loop) begin
                state_n = APPLY;
                idx_n   = '0;
            end else begin
                state_n = IDLE;
                finish  = 1'b1;
            end
        end
        if (stop) begin
            state_n = IDLE;
            finish  = 1'b0;
            idx_n   = step_idx;
        end
    end

    // Channel outputs, step index, done pulse and the tick/duration counters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pitches     <= '0;
            channel_ena <= '0;
            waveforms   <= '0;
            step_idx    <= '0;
            done        <= 1'b0;
            presc       <= '0;
            dur_cnt     <= '0;
            hold_last   <= 1'b0;
        end else begin
            done     <= finish;
            step_idx <= idx_n;
            if (stop) begin
                channel_ena <= '0;
            end else if (state == APPLY) begin
                for (int n = 0; n < NUM; n++) begin
                    if (cur.chan == CHW'(n)) begin
                        pitches[n*C +: C]   <= cur.pitch;
                        channel_ena[n]      <= cur.ena;
                        waveforms[n*2 +: 2] <= cur.wave;
                    end
                end
                dur_cnt   <= cur.dur;
                presc     <= '0;
                hold_last <= apply_last;
            end else if (state == HOLD) begin
                if (tick_wrap) begin
                    presc   <= '0;
                    dur_cnt <= dur_cnt - 1'b1;
                end else begin
                    presc <= presc + 1'b1;
                end
            end
        end
    end

endmodule
